// File: rtl/shift24_arb.sv
// Round-robin arbiter that time-shares one external 24-bit arithmetic right shifter
// among NREQ requesters and captures each result, tagged, in a one-deep output register.
module shift24_arb #(
    parameter int NREQ = 4,
    parameter int TAGW = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NREQ-1:0]      req_valid,
    input  logic [24*NREQ-1:0]   req_data,
    input  logic [5*NREQ-1:0]    req_shift,
    output logic [NREQ-1:0]      req_ready,
    output logic [23:0]          sh_d,
    output logic [4:0]           sh_s,
    input  logic [23:0]          sh_y,
    output logic                 out_valid,
    output logic [23:0]          out_data,
    output logic [TAGW-1:0]     out_tag,
    input  logic                 out_ready,
    output logic                 sat_flag,
    input  logic                 sat_clr
);

    typedef enum logic [0:0] {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } out_state_e;

    out_state_e          r_state;
    out_state_e          w_state_nxt;
    logic [TAGW-1:0]     r_ptr;
    logic [TAGW-1:0]     w_ptr_nxt;
    logic [23:0]         r_out_data;
    logic [TAGW-1:0]     r_out_tag;
    logic                r_sat_flag;

    logic                w_grant_found;
    logic [TAGW-1:0]     w_grant_idx;
    logic [TAGW-1:0]     w_scan_idx;
    logic                w_hit;
    logic [NREQ-1:0]     w_onehot_g;
    logic [23:0]         w_sel_data;
    logic [4:0]          w_sel_shift;
    logic                w_clamp;
    logic                w_can_acc;
    logic                w_accept;

    // Index of the requester 'off' positions above 'base', wrapping at NREQ.
    function automatic logic [TAGW-1:0] wrap_add(input logic [TAGW-1:0] base, input int off);
        int sum;
        sum = int'(base) + off;
        sum = (sum >= NREQ) ? (sum - NREQ) : sum;
        return sum[TAGW-1:0];
    endfunction

    // Rotating priority search: first pending request at or above the pointer.
    always_comb begin
        w_grant_found = 1'b0;
        w_grant_idx   = {TAGW{1'b0}};
        w_scan_idx    = {TAGW{1'b0}};
        w_hit         = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
            w_scan_idx    = wrap_add(r_ptr, k);
            w_hit         = ~w_grant_found & req_valid[w_scan_idx];
            w_grant_idx   = w_hit ? w_scan_idx : w_grant_idx;
            w_grant_found = w_grant_found | w_hit;
        end
    end

    // AND-OR mux of the granted requester's operand and shift amount.
    always_comb begin
        w_onehot_g  = {NREQ{1'b0}};
        w_sel_data  = 24'd0;
        w_sel_shift = 5'd0;
        for (int i = 0; i < NREQ; i++) begin
            w_onehot_g[i] = w_grant_found & (w_grant_idx == TAGW'(i));
            w_sel_data    = w_sel_data  | ({24{w_onehot_g[i]}} & req_data[24*i +: 24]);
            w_sel_shift   = w_sel_shift | ({5{w_onehot_g[i]}}  & req_shift[5*i +: 5]);
        end
    end

    // Shifts beyond 23 are clamped; the result is then pure sign fill either way.
    assign w_clamp   = (w_sel_shift > 5'd23);
    assign sh_d      = w_sel_data;
    assign sh_s      = w_clamp ? 5'd23 : w_sel_shift;

    assign w_can_acc = (r_state == ST_EMPTY) | out_ready;
    assign w_accept  = rst_n & w_can_acc & w_grant_found;
    assign req_ready = w_accept ? w_onehot_g : {NREQ{1'b0}};

    assign w_ptr_nxt = (w_grant_idx == TAGW'(NREQ - 1)) ? {TAGW{1'b0}}
                                                         : (w_grant_idx + TAGW'(1));

    // Output register occupancy: next-state decode.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_EMPTY: w_state_nxt = w_accept ? ST_FULL : ST_EMPTY;
            ST_FULL: begin
                if (out_ready) begin
                    w_state_nxt = w_accept ? ST_FULL : ST_EMPTY;
                end else begin
                    w_state_nxt = ST_FULL;
                end
            end
            default:  w_state_nxt = ST_EMPTY;
        endcase
    end

    // Output register occupancy: state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_EMPTY;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Priority pointer moves just past the winner, only on an accept.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr <= {TAGW{1'b0}};
        end else if (w_accept) begin
            r_ptr <= w_ptr_nxt;
        end else begin
            r_ptr <= r_ptr;
        end
    end

    // Result capture from the shared shifter with the winner's tag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_data <= 24'd0;
            r_out_tag  <= {TAGW{1'b0}};
        end else if (w_accept) begin
            r_out_data <= sh_y;
            r_out_tag  <= w_grant_idx;
        end else begin
            r_out_data <= r_out_data;
            r_out_tag  <= r_out_tag;
        end
    end

    // Sticky clamp indicator; a clamp in the same cycle as a clear keeps it set.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sat_flag <= 1'b0;
        end else if (w_accept && w_clamp) begin
            r_sat_flag <= 1'b1;
        end else if (sat_clr) begin
            r_sat_flag <= 1'b0;
        end else begin
            r_sat_flag <= r_sat_flag;
        end
    end

    assign out_valid = (r_state == ST_FULL);
    assign out_data  = r_out_data;
    assign out_tag   = r_out_tag;
    assign sat_flag  = r_sat_flag;

endmodule

// File: tb/tb_shift24_arb.sv
// Directed and randomized self-checking bench for shift24_arb with a behavioural
// shifter attached to the sh_d/sh_s/sh_y port trio.
module tb_shift24_arb;

    logic         clk;
    logic         rst_n;
    logic [3:0]   req_valid;
    logic [95:0]  req_data;
    logic [19:0]  req_shift;
    logic [3:0]   req_ready;
    logic [23:0]  sh_d;
    logic [4:0]   sh_s;
    logic [23:0]  sh_y;
    logic         out_valid;
    logic [23:0]  out_data;
    logic [1:0]   out_tag;
    logic         out_ready;
    logic         sat_flag;
    logic         sat_clr;

    int n_cmp;
    int n_err;

    shift24_arb #(.NREQ(4), .TAGW(2)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_shift (req_shift),
        .req_ready (req_ready),
        .sh_d      (sh_d),
        .sh_s      (sh_s),
        .sh_y      (sh_y),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_tag   (out_tag),
        .out_ready (out_ready),
        .sat_flag  (sat_flag),
        .sat_clr   (sat_clr)
    );

    assign sh_y = $signed(sh_d) >>> sh_s;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [23:0] ref_shift(input logic [23:0] d, input logic [4:0] s);
        logic signed [23:0] sd;
        int n;
        sd = d;
        n  = (s > 5'd23) ? 23 : int'(s);
        return sd >>> n;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n     = 1'b0;
        req_valid = 4'b0000;
        req_data  = 96'd0;
        req_shift = 20'd0;
        out_ready = 1'b0;
        sat_clr   = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n     = 1'b0;
        req_valid = 4'b1111;
        out_ready = 1'b1;
        #12;
        n_cmp++; if (req_ready !== 4'b0000) begin n_err++; $display("FAIL rst_ready got %b want 0000", req_ready); end
        n_cmp++; if (out_valid !== 1'b0)    begin n_err++; $display("FAIL rst_valid got %b want 0", out_valid); end
        n_cmp++; if (out_data !== 24'h0)    begin n_err++; $display("FAIL rst_data got %h want 000000", out_data); end
        n_cmp++; if (out_tag !== 2'd0)      begin n_err++; $display("FAIL rst_tag got %0d want 0", out_tag); end
        n_cmp++; if (sat_flag !== 1'b0)     begin n_err++; $display("FAIL rst_sat got %b want 0", sat_flag); end
    endtask

    task automatic test_single();
        do_reset();
        req_valid       = 4'b0001;
        req_data[23:0]  = 24'h800000;
        req_shift[4:0]  = 5'd4;
        out_ready       = 1'b1;
        #1;
        n_cmp++; if (req_ready !== 4'b0001) begin n_err++; $display("FAIL single_ready got %b want 0001", req_ready); end
        n_cmp++; if (sh_d !== 24'h800000)   begin n_err++; $display("FAIL single_shd got %h want 800000", sh_d); end
        n_cmp++; if (sh_s !== 5'd4)         begin n_err++; $display("FAIL single_shs got %0d want 4", sh_s); end
        tick();
        req_valid = 4'b0000;
        #1;
        n_cmp++; if (out_valid !== 1'b1)     begin n_err++; $display("FAIL single_valid got %b want 1", out_valid); end
        n_cmp++; if (out_data !== 24'hF80000) begin n_err++; $display("FAIL single_data got %h want f80000", out_data); end
        n_cmp++; if (out_tag !== 2'd0)       begin n_err++; $display("FAIL single_tag got %0d want 0", out_tag); end
        tick();
        n_cmp++; if (out_valid !== 1'b0)     begin n_err++; $display("FAIL single_drain got %b want 0", out_valid); end
    endtask

    task automatic test_round_robin();
        logic [23:0] exp_d [4];
        exp_d[0] = 24'h123456;
        exp_d[1] = 24'hC00000;
        exp_d[2] = 24'h007FFF;
        exp_d[3] = 24'hFF0F0F;
        do_reset();
        req_data  = {24'hF0F0F0, 24'h7FFFFF, 24'h800000, 24'h123456};
        req_shift = {5'd4, 5'd8, 5'd1, 5'd0};
        req_valid = 4'b1111;
        out_ready = 1'b1;
        for (int c = 0; c < 6; c++) begin
            #1;
            n_cmp++; if (req_ready !== (4'b0001 << (c % 4))) begin n_err++; $display("FAIL rr_ready[%0d] got %b want %b", c, req_ready, 4'b0001 << (c % 4)); end
            tick();
            n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL rr_valid[%0d] got %b want 1", c, out_valid); end
            n_cmp++; if (out_tag !== 2'(c % 4)) begin n_err++; $display("FAIL rr_tag[%0d] got %0d want %0d", c, out_tag, c % 4); end
            n_cmp++; if (out_data !== exp_d[c % 4]) begin n_err++; $display("FAIL rr_data[%0d] got %h want %h", c, out_data, exp_d[c % 4]); end
        end
        req_valid = 4'b0000;
    endtask

    task automatic test_back_to_back();
        do_reset();
        req_data  = {24'hF0F0F0, 24'h7FFFFF, 24'h800000, 24'h123456};
        req_shift = {5'd4, 5'd8, 5'd1, 5'd0};
        req_valid = 4'b0001;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        req_valid = 4'b0110;
        for (int c = 0; c < 3; c++) begin
            #1;
            n_cmp++; if (req_ready !== 4'b0000)  begin n_err++; $display("FAIL hold_ready[%0d] got %b want 0000", c, req_ready); end
            n_cmp++; if (out_data !== 24'h123456) begin n_err++; $display("FAIL hold_data[%0d] got %h want 123456", c, out_data); end
            n_cmp++; if (out_tag !== 2'd0)        begin n_err++; $display("FAIL hold_tag[%0d] got %0d want 0", c, out_tag); end
            n_cmp++; if (out_valid !== 1'b1)      begin n_err++; $display("FAIL hold_valid[%0d] got %b want 1", c, out_valid); end
            tick();
        end
        out_ready = 1'b1;
        #1;
        n_cmp++; if (req_ready !== 4'b0010) begin n_err++; $display("FAIL release_ready got %b want 0010", req_ready); end
        tick();
        req_valid = 4'b0000;
        #1;
        n_cmp++; if (out_tag !== 2'd1)        begin n_err++; $display("FAIL release_tag got %0d want 1", out_tag); end
        n_cmp++; if (out_data !== 24'hC00000) begin n_err++; $display("FAIL release_data got %h want c00000", out_data); end
    endtask

    task automatic test_saturate();
        do_reset();
        out_ready         = 1'b1;
        req_data[71:48]   = 24'h7FFFFF;
        req_shift[14:10]  = 5'd31;
        req_valid         = 4'b0100;
        #1;
        n_cmp++; if (req_ready !== 4'b0100) begin n_err++; $display("FAIL sat_ready got %b want 0100", req_ready); end
        n_cmp++; if (sh_s !== 5'd23)        begin n_err++; $display("FAIL sat_shs got %0d want 23", sh_s); end
        tick();
        req_valid = 4'b0000;
        #1;
        n_cmp++; if (out_data !== 24'h000000) begin n_err++; $display("FAIL sat_pos_data got %h want 000000", out_data); end
        n_cmp++; if (sat_flag !== 1'b1)       begin n_err++; $display("FAIL sat_set got %b want 1", sat_flag); end
        sat_clr = 1'b1;
        tick();
        sat_clr = 1'b0;
        n_cmp++; if (sat_flag !== 1'b0)       begin n_err++; $display("FAIL sat_clear got %b want 0", sat_flag); end
        req_data[71:48] = 24'h800001;
        req_valid       = 4'b0100;
        tick();
        req_valid = 4'b0000;
        #1;
        n_cmp++; if (out_data !== 24'hFFFFFF) begin n_err++; $display("FAIL sat_neg_data got %h want ffffff", out_data); end
        n_cmp++; if (sat_flag !== 1'b1)       begin n_err++; $display("FAIL sat_neg_set got %b want 1", sat_flag); end
        sat_clr = 1'b1;
        tick();
        req_valid = 4'b0100;
        tick();
        req_valid = 4'b0000;
        sat_clr   = 1'b0;
        #1;
        n_cmp++; if (sat_flag !== 1'b1)       begin n_err++; $display("FAIL sat_set_wins got %b want 1", sat_flag); end
        sat_clr = 1'b1;
        tick();
        sat_clr          = 1'b0;
        req_shift[14:10] = 5'd23;
        req_valid        = 4'b0100;
        #1;
        n_cmp++; if (sh_s !== 5'd23)          begin n_err++; $display("FAIL edge23_shs got %0d want 23", sh_s); end
        tick();
        req_valid = 4'b0000;
        #1;
        n_cmp++; if (out_data !== 24'hFFFFFF) begin n_err++; $display("FAIL edge23_data got %h want ffffff", out_data); end
        n_cmp++; if (sat_flag !== 1'b0)       begin n_err++; $display("FAIL edge23_noset got %b want 0", sat_flag); end
    endtask

    task automatic test_reset_midop();
        do_reset();
        req_data  = {24'hF0F0F0, 24'h7FFFFF, 24'h800000, 24'h123456};
        req_shift = {5'd4, 5'd8, 5'd1, 5'd0};
        out_ready = 1'b1;
        req_valid = 4'b0010;
        tick();
        out_ready = 1'b0;
        req_valid = 4'b1111;
        #1;
        n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL mid_pre_valid got %b want 1", out_valid); end
        #2;
        rst_n = 1'b0;
        #1;
        n_cmp++; if (out_valid !== 1'b0)    begin n_err++; $display("FAIL mid_async_valid got %b want 0", out_valid); end
        n_cmp++; if (req_ready !== 4'b0000) begin n_err++; $display("FAIL mid_async_ready got %b want 0000", req_ready); end
        tick();
        rst_n = 1'b1;
        #1;
        n_cmp++; if (req_ready !== 4'b0001) begin n_err++; $display("FAIL mid_prio_ready got %b want 0001", req_ready); end
        tick();
        req_valid = 4'b0000;
        #1;
        n_cmp++; if (out_tag !== 2'd0)        begin n_err++; $display("FAIL mid_prio_tag got %0d want 0", out_tag); end
        n_cmp++; if (out_data !== 24'h123456) begin n_err++; $display("FAIL mid_prio_data got %h want 123456", out_data); end
    endtask

    task automatic test_random();
        logic [3:0]  pend;
        logic [23:0] rd [4];
        logic [4:0]  rs [4];
        int          wait_cnt [4];
        int          m_ptr;
        logic        m_full;
        logic [23:0] m_data;
        logic [1:0]  m_tag;
        int          eg;
        int          idx;
        logic        can;
        logic [3:0]  exp_ready;
        do_reset();
        pend   = 4'b0000;
        m_ptr  = 0;
        m_full = 1'b0;
        m_data = 24'd0;
        m_tag  = 2'd0;
        for (int i = 0; i < 4; i++) begin
            rd[i] = 24'd0;
            rs[i] = 5'd0;
            wait_cnt[i] = 0;
        end
        for (int cyc = 0; cyc < 1500; cyc++) begin
            for (int i = 0; i < 4; i++) begin
                if (!pend[i] && ($urandom_range(0, 1) == 1)) begin
                    pend[i] = 1'b1;
                    rd[i]   = 24'($urandom);
                    rs[i]   = 5'($urandom_range(0, 31));
                    wait_cnt[i] = 0;
                end
            end
            req_valid = pend;
            req_data  = {rd[3], rd[2], rd[1], rd[0]};
            req_shift = {rs[3], rs[2], rs[1], rs[0]};
            out_ready = ($urandom_range(0, 3) != 0);
            #1;
            eg = -1;
            for (int k = 0; k < 4; k++) begin
                idx = (m_ptr + k) % 4;
                if (eg < 0 && pend[idx]) eg = idx;
            end
            can       = !m_full || out_ready;
            exp_ready = (eg >= 0 && can) ? (4'b0001 << eg) : 4'b0000;
            n_cmp++; if (req_ready !== exp_ready) begin n_err++; $display("FAIL rnd_ready[%0d] got %b want %b", cyc, req_ready, exp_ready); end
            n_cmp++; if (out_valid !== m_full)    begin n_err++; $display("FAIL rnd_valid[%0d] got %b want %b", cyc, out_valid, m_full); end
            if (m_full && out_ready) begin
                n_cmp++; if (out_data !== m_data) begin n_err++; $display("FAIL rnd_data[%0d] got %h want %h", cyc, out_data, m_data); end
                n_cmp++; if (out_tag !== m_tag)   begin n_err++; $display("FAIL rnd_tag[%0d] got %0d want %0d", cyc, out_tag, m_tag); end
            end
            if (exp_ready != 4'b0000) begin
                n_cmp++; if (wait_cnt[eg] > 64) begin n_err++; $display("FAIL rnd_starve[%0d] got wait %0d want <=64", eg, wait_cnt[eg]); end
                m_full   = 1'b1;
                m_data   = ref_shift(rd[eg], rs[eg]);
                m_tag    = 2'(eg);
                m_ptr    = (eg + 1) % 4;
                pend[eg] = 1'b0;
            end else if (out_ready) begin
                m_full = 1'b0;
            end
            for (int i = 0; i < 4; i++) begin
                if (pend[i]) wait_cnt[i]++;
            end
            tick();
        end
        req_valid = 4'b0000;
        out_ready = 1'b0;
    endtask

    initial begin
        n_cmp     = 0;
        n_err     = 0;
        rst_n     = 1'b0;
        req_valid = 4'b0000;
        req_data  = 96'd0;
        req_shift = 20'd0;
        out_ready = 1'b0;
        sat_clr   = 1'b0;
        test_reset();
        test_single();
        test_round_robin();
        test_back_to_back();
        test_saturate();
        test_reset_midop();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
